branch_resolve_ctrl: RTL

Execute-stage branch resolution controller for the pipelined RV32I core. It configures the combinational branch comparator by driving its unsigned-select, and decodes the comparator's less/equal flags against funct3 into a taken decision. It compares that decision with the fetch-stage prediction. On a mismatch it issues a registered one-cycle redirect and sequences a multi-cycle front-end flush. It also keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// branch_resolve_ctrl : EX-stage branch decode, mispredict redirect, flush FSM
// Rev 1.0
// ============================================================================
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic            stall_i,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  output logic            br_unsigned_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            illegal_br_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            illegal_br_q, illegal_br_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;

  logic            eval;
  logic            taken;
  logic            illegal_dec;
  logic            mispredict;

  assign br_unsigned_o = ex_funct3_i[1];

  assign eval = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & ~stall_i
                & (state_q == ST_IDLE);

  // Jumps win over funct3, including when both type flags are raised.
  always_comb begin
    taken       = 1'b0;
    illegal_dec = 1'b0;
    if (ex_is_jump_i) begin
      taken = 1'b1;
    end else begin
      case (ex_funct3_i)
        3'b000:         taken = br_equal_i;
        3'b001:         taken = ~br_equal_i;
        3'b100, 3'b110: taken = br_less_i;
        3'b101, 3'b111: taken = ~br_less_i;
        default:        illegal_dec = 1'b1;
      endcase
    end
  end

  assign mispredict = taken ^ ex_pred_taken_i;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    illegal_br_d     = eval & illegal_dec;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (eval) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (eval && mispredict) begin
          state_d          = ST_FLUSH;
          cnt_d            = FLUSH_INIT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = taken ? ex_target_i : (ex_pc_i + PC_STEP);
        end
      end
      ST_FLUSH: begin
        // A stalled pipeline has not consumed a flush cycle yet.
        if (!stall_i) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    flush_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      illegal_br_q     <= 1'b0;
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      illegal_br_q     <= illegal_br_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign illegal_br_o     = illegal_br_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
`default_nettype wire
